spi_controller_v1: RTL and testbench

//   SPI mode-0 (CPOL=0, CPHA=0) controller: generates CSN/SCK/MOSI from sys_clk, samples MISO.

---
 rtl/spi_controller_v1.sv | 206 ++++++++++++++++++++
 tb/tb_spi_controller_v1.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller_v1.sv
// SPI mode-0 controller: frames one byte per TX_START with CSN, drives SCK/MOSI MSB first, samples MISO.
// Define SPI_BURST_EN to keep CSN low across bytes requested with TX_HOLD_CS (LINGER state).
//   state  | meaning
//   IDLE   | CSN high, waiting for TX_START
//   SETUP  | CSN low, SCK low before the first rising edge
//   SHIFT  | SCK toggling, 2*BYTE_W edges
//   HOLD   | CSN still low after the last falling edge
//   GAP    | CSN high minimum gap before the next frame
//   LINGER | burst only: CSN held low between bytes, ready for the next start
module spi_controller_v1 #(
  parameter int BYTE_W   = 8,
  parameter int CLK_DIV  = 3,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] TX_DATA,
  input  logic              TX_START,
  input  logic              TX_HOLD_CS,
  output logic              BUSY,
  output logic              DONE,
  output logic [BYTE_W-1:0] RX_DATA,
  output logic              CSN_PAD,
  output logic              SCK_PAD,
  output logic              MOSI_PAD,
  input  logic              MISO_PAD
);

  localparam int TMR_MAX = (CLK_DIV > CS_SETUP) ?
                           ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                           ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int EDGES   = 2 * BYTE_W;
  localparam int EDGE_W  = $clog2(EDGES + 1);

  localparam logic [TMR_W-1:0]  TMR_SETUP = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0]  TMR_HOLD  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0]  TMR_DIV   = TMR_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

`ifdef SPI_BURST_EN
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_LINGER} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
`endif

  state_t              state, state_n;
  logic [TMR_W-1:0]    tmr, tmr_n;
  logic [EDGE_W-1:0]   edge_cnt, edge_cnt_n;
  logic                sck, sck_n;
  logic                csn, csn_n;
  logic                mosi, mosi_n;
  logic                busy, busy_n;
  logic                done, done_n;
  logic [BYTE_W-1:0]   rx_data, rx_data_n;
  logic [BYTE_W-1:0]   tx_shift, tx_shift_n;
  logic [BYTE_W-1:0]   rx_shift, rx_shift_n;
  logic                miso_q;
  logic                accept;

`ifdef SPI_BURST_EN
  logic                hold_cs, hold_cs_n;
`else
  logic                unused_hold_cs;
  assign unused_hold_cs = TX_HOLD_CS;
`endif

  always_comb begin
    state_n    = state;
    tmr_n      = tmr;
    edge_cnt_n = edge_cnt;
    sck_n      = sck;
    csn_n      = csn;
    mosi_n     = mosi;
    busy_n     = busy;
    done_n     = 1'b0;
    rx_data_n  = rx_data;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    accept     = 1'b0;
`ifdef SPI_BURST_EN
    hold_cs_n  = hold_cs;
`endif

    case (state)
      S_IDLE: accept = TX_START;
`ifdef SPI_BURST_EN
      S_LINGER: accept = TX_START;
`endif
      S_SETUP: begin
        if (tmr == '0) begin
          state_n = S_SHIFT;
          tmr_n   = TMR_DIV;
        end else begin
          tmr_n = tmr - TMR_W'(1);
        end
      end
      S_SHIFT: begin
        if (tmr != '0) begin
          tmr_n = tmr - TMR_W'(1);
        end else begin
          tmr_n      = TMR_DIV;
          sck_n      = ~sck;
          edge_cnt_n = edge_cnt + EDGE_W'(1);
          if (!sck) begin
            rx_shift_n = {rx_shift[BYTE_W-2:0], miso_q};
          end else if (edge_cnt != EDGE_LAST) begin
            tx_shift_n = tx_shift << 1;
            mosi_n     = tx_shift[BYTE_W-2];
          end else begin
            rx_data_n = rx_shift;
            done_n    = 1'b1;
            state_n   = S_HOLD;
            tmr_n     = TMR_HOLD;
`ifdef SPI_BURST_EN
            if (hold_cs) begin
              state_n = S_LINGER;
              busy_n  = 1'b0;
            end
`endif
          end
        end
      end
      S_HOLD: begin
        if (tmr == '0) begin
          csn_n   = 1'b1;
          mosi_n  = 1'b0;
          state_n = S_GAP;
          tmr_n   = TMR_SETUP;
        end else begin
          tmr_n = tmr - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (tmr == '0) begin
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          tmr_n = tmr - TMR_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A start from LINGER has CSN already low, so it only waits one SCK half-period.
    if (accept) begin
      tx_shift_n = TX_DATA;
      mosi_n     = TX_DATA[BYTE_W-1];
      csn_n      = 1'b0;
      sck_n      = 1'b0;
      busy_n     = 1'b1;
      edge_cnt_n = '0;
      rx_shift_n = '0;
      state_n    = S_SETUP;
      tmr_n      = (state == S_IDLE) ? TMR_SETUP : TMR_DIV;
`ifdef SPI_BURST_EN
      hold_cs_n  = TX_HOLD_CS;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tmr      <= '0;
      edge_cnt <= '0;
      sck      <= 1'b0;
      csn      <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      miso_q   <= 1'b0;
`ifdef SPI_BURST_EN
      hold_cs  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      edge_cnt <= edge_cnt_n;
      sck      <= sck_n;
      csn      <= csn_n;
      mosi     <= mosi_n;
      busy     <= busy_n;
      done     <= done_n;
      rx_data  <= rx_data_n;
      tx_shift <= tx_shift_n;
      rx_shift <= rx_shift_n;
      miso_q   <= MISO_PAD;
`ifdef SPI_BURST_EN
      hold_cs  <= hold_cs_n;
`endif
    end
  end

  assign BUSY     = busy;
  assign DONE     = done;
  assign RX_DATA  = rx_data;
  assign CSN_PAD  = csn;
  assign SCK_PAD  = sck;
  assign MOSI_PAD = mosi;

endmodule

// File: tb/tb_spi_controller_v1.sv
// Directed bench for spi_controller_v1 with a mode-0 peripheral model (loopback or fixed reply byte).
module tb_spi_controller_v1;

  localparam int BYTE_W   = 8;
  localparam int CLK_DIV  = 3;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int T_CLK    = 20;
  localparam int FRAME    = 1 + CS_SETUP + 2 * BYTE_W * CLK_DIV + CS_HOLD + CS_SETUP;

  logic              sys_clk;
  logic              rst;
  logic [BYTE_W-1:0] TX_DATA;
  logic              TX_START;
  logic              TX_HOLD_CS;
  logic              BUSY;
  logic              DONE;
  logic [BYTE_W-1:0] RX_DATA;
  logic              CSN_PAD;
  logic              SCK_PAD;
  logic              MOSI_PAD;
  logic              MISO_PAD;

  int checks = 0;
  int errors = 0;

  spi_controller_v1 #(
    .BYTE_W(BYTE_W), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .TX_DATA(TX_DATA), .TX_START(TX_START),
    .TX_HOLD_CS(TX_HOLD_CS), .BUSY(BUSY), .DONE(DONE), .RX_DATA(RX_DATA),
    .CSN_PAD(CSN_PAD), .SCK_PAD(SCK_PAD), .MOSI_PAD(MOSI_PAD), .MISO_PAD(MISO_PAD)
  );

  initial sys_clk = 1'b0;
  always #(T_CLK / 2) sys_clk = ~sys_clk;

  // peripheral: loads its reply on CSN fall, shifts on SCK fall, samples MOSI on SCK rise
  logic              loopback = 1'b1;
  logic [BYTE_W-1:0] p_data = '0;
  logic [BYTE_W-1:0] p_sh = '0;
  logic [BYTE_W-1:0] p_rx = '0;
  assign MISO_PAD = loopback ? MOSI_PAD : p_sh[BYTE_W-1];

  always @(negedge CSN_PAD) p_sh = p_data;
  always @(negedge SCK_PAD) if (CSN_PAD === 1'b0) p_sh = p_sh << 1;
  always @(posedge SCK_PAD) if (CSN_PAD === 1'b0) p_rx = {p_rx[BYTE_W-2:0], MOSI_PAD};

  int  sck_edges = 0;
  time last_edge = 0, hp_min = 0, hp_max = 0, last_rise = 0, rise_per = 0;
  always @(posedge SCK_PAD or negedge SCK_PAD) begin
    sck_edges++;
    if (last_edge != 0) begin
      if ($time - last_edge < hp_min) hp_min = $time - last_edge;
      if ($time - last_edge > hp_max) hp_max = $time - last_edge;
    end
    last_edge = $time;
  end
  always @(posedge SCK_PAD) begin
    if (last_rise != 0) rise_per = $time - last_rise;
    last_rise = $time;
  end

  int                done_cnt = 0, csn_falls = 0, csn_high_run = 0, gap_last = 0, rx_n = 0;
  logic [BYTE_W-1:0] rx_log [16];
  always @(negedge sys_clk) begin
    if (DONE === 1'b1) begin
      done_cnt++;
      if (rx_n < 16) rx_log[rx_n] = RX_DATA;
      rx_n++;
    end
    if (CSN_PAD === 1'b1) csn_high_run++;
    else if (CSN_PAD === 1'b0) begin
      if (csn_high_run > 0) begin
        gap_last = csn_high_run;
        csn_falls++;
      end
      csn_high_run = 0;
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic start_byte(input logic [BYTE_W-1:0] d, input logic hold);
    TX_DATA    = d;
    TX_HOLD_CS = hold;
    TX_START   = 1'b1;
    step();
    TX_START   = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      cycles++;
      if (BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic reset_sck_mon();
    sck_edges = 0;
    last_edge = 0;
    hp_min    = 64'd1_000_000;
    hp_max    = 0;
    last_rise = 0;
    rise_per  = 0;
  endtask

  task automatic test_reset();
    int d0;
    rst = 1'b1; TX_START = 1'b0; TX_DATA = '0; TX_HOLD_CS = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (CSN_PAD !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b expected 1", CSN_PAD); end
    checks++; if (SCK_PAD !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", SCK_PAD); end
    checks++; if (MOSI_PAD !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", MOSI_PAD); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h expected 00", RX_DATA); end

    loopback = 1'b1;
    d0 = done_cnt;
    start_byte(8'hC3, 1'b0);
    repeat (20) step();
    checks++; if ({BUSY, CSN_PAD} !== 2'b10) begin errors++; $display("FAIL midframe_active: got busy/csn %b expected 10", {BUSY, CSN_PAD}); end
    rst = 1'b1;
    repeat (3) step();
    checks++; if ({CSN_PAD, SCK_PAD, BUSY, DONE} !== 4'b1000) begin errors++; $display("FAIL midframe_reset: got csn/sck/busy/done %b expected 1000", {CSN_PAD, SCK_PAD, BUSY, DONE}); end
    rst = 1'b0;
    repeat (60) step();
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL midframe_no_done: got %0d pulses expected 0", done_cnt - d0); end
    checks++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL midframe_rx: got %h expected 00", RX_DATA); end
    checks++; if (CSN_PAD !== 1'b1) begin errors++; $display("FAIL midframe_csn_idle: got %b expected 1", CSN_PAD); end
  endtask

  task automatic test_loopback();
    int d0, c;
    bit ok;
    loopback = 1'b1;
    reset_sck_mon();
    d0 = done_cnt; rx_n = 0;
    start_byte(8'hA5, 1'b0);
    wait_not_busy(200, c, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_timeout: busy still %b after %0d cycles", BUSY, c); end
    checks++; if (sck_edges !== 2 * BYTE_W) begin errors++; $display("FAIL loop_edges: got %0d expected %0d", sck_edges, 2 * BYTE_W); end
    checks++; if (hp_min !== CLK_DIV * T_CLK || hp_max !== CLK_DIV * T_CLK) begin errors++; $display("FAIL loop_half_period: got %0t..%0t expected %0d", hp_min, hp_max, CLK_DIV * T_CLK); end
    checks++; if (rise_per !== 2 * CLK_DIV * T_CLK) begin errors++; $display("FAIL loop_period: got %0t expected %0d", rise_per, 2 * CLK_DIV * T_CLK); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL loop_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (rx_log[0] !== 8'hA5) begin errors++; $display("FAIL loop_rx_at_done: got %h expected a5", rx_log[0]); end
    checks++; if (RX_DATA !== 8'hA5) begin errors++; $display("FAIL loop_rx_held: got %h expected a5", RX_DATA); end
  endtask

  task automatic test_peripheral();
    int c;
    bit ok;
    loopback = 1'b0;
    p_data = 8'h80;
    p_rx = '0;
    start_byte(8'h3C, 1'b0);
    wait_not_busy(200, c, ok);
    checks++; if (!ok) begin errors++; $display("FAIL periph_timeout: busy still %b after %0d cycles", BUSY, c); end
    checks++; if (p_rx !== 8'h3C) begin errors++; $display("FAIL periph_mosi_bits: got %h expected 3c", p_rx); end
    checks++; if (RX_DATA !== 8'h80) begin errors++; $display("FAIL periph_rx: got %h expected 80", RX_DATA); end
    loopback = 1'b1;
  endtask

  task automatic test_busy_ignore();
    int d0, f0, cycles;
    loopback = 1'b1;
    d0 = done_cnt; f0 = csn_falls;
    start_byte(8'h5A, 1'b0);
    cycles = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      cycles++;
      if (BUSY === 1'b0) begin
        TX_START = 1'b0;
        break;
      end
      if (i == 3) TX_DATA = 8'hFF;
      TX_START = (i == 10 || i == 30 || i == 52);
    end
    checks++; if (cycles !== FRAME) begin errors++; $display("FAIL busy_frame_len: got %0d expected %0d", cycles, FRAME); end
    repeat (10) step();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL busy_no_queue: got %b expected 0", BUSY); end
    checks++; if (csn_falls - f0 !== 1) begin errors++; $display("FAIL busy_frames: got %0d expected 1", csn_falls - f0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (RX_DATA !== 8'h5A) begin errors++; $display("FAIL busy_latched_data: got %h expected 5a", RX_DATA); end
  endtask

  task automatic test_back_to_back();
    int d0, f0, c1, c2;
    bit ok1, ok2;
    loopback = 1'b1;
    d0 = done_cnt; f0 = csn_falls; rx_n = 0;
    start_byte(8'h11, 1'b0);
    wait_not_busy(200, c1, ok1);
    start_byte(8'h22, 1'b0);
    wait_not_busy(200, c2, ok2);
    repeat (3) step();
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_timeout: got ok %b%b expected 11", ok1, ok2); end
    checks++; if (c1 + 1 !== FRAME) begin errors++; $display("FAIL b2b_frame_len: got %0d expected %0d", c1 + 1, FRAME); end
    checks++; if (gap_last !== CS_SETUP + 1) begin errors++; $display("FAIL b2b_csn_gap: got %0d expected %0d", gap_last, CS_SETUP + 1); end
    checks++; if (csn_falls - f0 !== 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", csn_falls - f0); end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
    checks++; if (rx_log[0] !== 8'h11 || rx_log[1] !== 8'h22) begin errors++; $display("FAIL b2b_rx: got %h %h expected 11 22", rx_log[0], rx_log[1]); end
  endtask

`ifdef SPI_BURST_EN
  task automatic test_burst();
    int d0, f0, c;
    bit ok;
    loopback = 1'b1;
    d0 = done_cnt; f0 = csn_falls; rx_n = 0;
    start_byte(8'h81, 1'b1);
    wait_not_busy(200, c, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout1: busy still %b after %0d cycles", BUSY, c); end
    repeat (5) step();
    checks++; if ({CSN_PAD, SCK_PAD, BUSY} !== 3'b000) begin errors++; $display("FAIL burst_linger: got csn/sck/busy %b expected 000", {CSN_PAD, SCK_PAD, BUSY}); end
    start_byte(8'h42, 1'b1);
    wait_not_busy(200, c, ok);
    start_byte(8'hE7, 1'b0);
    wait_not_busy(200, c, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout3: busy still %b after %0d cycles", BUSY, c); end
    repeat (3) step();
    checks++; if (CSN_PAD !== 1'b1) begin errors++; $display("FAIL burst_csn_end: got %b expected 1", CSN_PAD); end
    checks++; if (csn_falls - f0 !== 1) begin errors++; $display("FAIL burst_windows: got %0d expected 1", csn_falls - f0); end
    checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL burst_done_count: got %0d expected 3", done_cnt - d0); end
    checks++; if (rx_log[0] !== 8'h81 || rx_log[1] !== 8'h42 || rx_log[2] !== 8'hE7) begin errors++; $display("FAIL burst_rx: got %h %h %h expected 81 42 e7", rx_log[0], rx_log[1], rx_log[2]); end
  endtask
`else
  task automatic test_hold_cs_ignored();
    int c;
    bit ok;
    loopback = 1'b1;
    start_byte(8'h96, 1'b1);
    wait_not_busy(200, c, ok);
    checks++; if (c + 1 !== FRAME) begin errors++; $display("FAIL holdcs_frame_len: got %0d expected %0d", c + 1, FRAME); end
    checks++; if (CSN_PAD !== 1'b1) begin errors++; $display("FAIL holdcs_csn: got %b expected 1", CSN_PAD); end
    checks++; if (RX_DATA !== 8'h96) begin errors++; $display("FAIL holdcs_rx: got %h expected 96", RX_DATA); end
  endtask
`endif

  initial begin
    rst = 1'b1; TX_START = 1'b0; TX_DATA = '0; TX_HOLD_CS = 1'b0;
    test_reset();
    test_loopback();
    test_peripheral();
    test_busy_ignore();
    test_back_to_back();
`ifdef SPI_BURST_EN
    test_burst();
`else
    test_hold_cs_ignored();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(T_CLK * 20000);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
